// File: rtl/cdb_arb.sv
// cdb_arb: per-source completion buffers arbitrated onto one registered CDB broadcast.
// Define CDB_ARB_MUL_PRIO_EN to give source 0 (mul) fixed priority over the round-robin.
module cdb_arb #(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_BITS   = 5,
    parameter int PREG_BITS  = 6,
    parameter int BR_BITS    = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_SRC-1:0]                           src_valid,
    output logic [NUM_SRC-1:0]                           src_ready,
    input  logic [NUM_SRC*32-1:0]                        src_data,
    input  logic [NUM_SRC*ROB_BITS-1:0]                  src_rob,
    input  logic [NUM_SRC*5-1:0]                         src_rd,
    input  logic [NUM_SRC*PREG_BITS-1:0]                 src_pd,
    input  logic [NUM_SRC*BR_BITS-1:0]                   src_mask,
    input  logic                                         br_valid,
    input  logic                                         br_mispred,
    input  logic [$clog2((BR_BITS > 1) ? BR_BITS : 2)-1:0] br_idx,
    output logic                                         cdb_valid,
    output logic [31:0]                                  cdb_data,
    output logic [ROB_BITS-1:0]                          cdb_rob,
    output logic [4:0]                                   cdb_rd,
    output logic [PREG_BITS-1:0]                         cdb_pd
);
    localparam int PW = $clog2((FIFO_DEPTH > 1) ? FIFO_DEPTH : 2);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2((NUM_SRC > 1) ? NUM_SRC : 2);

`ifdef CDB_ARB_MUL_PRIO_EN
    localparam logic MUL_PRIO = 1'b1;
`else
    localparam logic MUL_PRIO = 1'b0;
`endif

    logic                 ent_v_q    [NUM_SRC][FIFO_DEPTH];
    logic [BR_BITS-1:0]   ent_mask_q [NUM_SRC][FIFO_DEPTH];
    logic [31:0]          ent_data_q [NUM_SRC][FIFO_DEPTH];
    logic [ROB_BITS-1:0]  ent_rob_q  [NUM_SRC][FIFO_DEPTH];
    logic [4:0]           ent_rd_q   [NUM_SRC][FIFO_DEPTH];
    logic [PREG_BITS-1:0] ent_pd_q   [NUM_SRC][FIFO_DEPTH];

    logic [PW-1:0] head_q [NUM_SRC];
    logic [PW-1:0] head_d [NUM_SRC];
    logic [PW-1:0] tail_q [NUM_SRC];
    logic [PW-1:0] tail_d [NUM_SRC];
    logic [CW-1:0] occ_q  [NUM_SRC];
    logic [CW-1:0] occ_d  [NUM_SRC];
    logic [SW-1:0] rr_q, rr_d;

    logic                 out_valid_q;
    logic [31:0]          out_data_q;
    logic [ROB_BITS-1:0]  out_rob_q;
    logic [4:0]           out_rd_q;
    logic [PREG_BITS-1:0] out_pd_q;
    logic [BR_BITS-1:0]   out_mask_q;

    logic               flush;
    logic [BR_BITS-1:0] keep_mask;
    logic [BR_BITS-1:0] in_mask [NUM_SRC];
    logic [NUM_SRC-1:0] in_kill, push, pop, cand, drop;
    logic               gnt_any;
    logic [SW-1:0]      gnt_idx;
    logic [PW-1:0]      gnt_head;
    int unsigned        scan;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign flush     = br_valid & br_mispred;
    assign keep_mask = br_valid ? ~(BR_BITS'(1) << br_idx) : '1;

    // Heads flushed this cycle are not candidates; already-invalid heads are dropped.
    always_comb begin
        cand      = '0;
        drop      = '0;
        in_kill   = '0;
        src_ready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            in_mask[i]   = src_mask[i*BR_BITS +: BR_BITS];
            in_kill[i]   = flush & in_mask[i][br_idx];
            src_ready[i] = occ_q[i] < CW'(FIFO_DEPTH);
            if (occ_q[i] != '0) begin
                if (ent_v_q[i][head_q[i]]) begin
                    cand[i] = ~(flush & ent_mask_q[i][head_q[i]][br_idx]);
                end else begin
                    drop[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_d    = rr_q;
        scan    = 0;
        if (MUL_PRIO && cand[0]) begin
            gnt_any = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                scan = 32'(rr_q) + k;
                if (scan >= 32'(NUM_SRC)) scan = scan - 32'(NUM_SRC);
                if (!gnt_any && cand[SW'(scan)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SW'(scan);
                end
            end
            if (gnt_any) rr_d = (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign gnt_head = head_q[gnt_idx];

    always_comb begin
        push = src_valid & src_ready;
        pop  = drop;
        if (gnt_any) pop[gnt_idx] = 1'b1;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            occ_d[i]  = occ_q[i] + CW'(push[i]) - CW'(pop[i]);
            head_d[i] = pop[i]  ? ptr_inc(head_q[i]) : head_q[i];
            tail_d[i] = push[i] ? ptr_inc(tail_q[i]) : tail_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                occ_q[i]  <= '0;
                head_q[i] <= '0;
                tail_q[i] <= '0;
                for (int unsigned j = 0; j < FIFO_DEPTH; j++) ent_v_q[i][j] <= 1'b0;
            end
            rr_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                occ_q[i]  <= occ_d[i];
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
                    if (flush && ent_mask_q[i][j][br_idx]) ent_v_q[i][j] <= 1'b0;
                end
                if (push[i]) ent_v_q[i][tail_q[i]] <= ~in_kill[i];
            end
            rr_q        <= rr_d;
            out_valid_q <= gnt_any;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
                ent_mask_q[i][j] <= ent_mask_q[i][j] & keep_mask;
            end
            if (push[i]) begin
                ent_data_q[i][tail_q[i]] <= src_data[i*32 +: 32];
                ent_rob_q[i][tail_q[i]]  <= src_rob[i*ROB_BITS +: ROB_BITS];
                ent_rd_q[i][tail_q[i]]   <= src_rd[i*5 +: 5];
                ent_pd_q[i][tail_q[i]]   <= src_pd[i*PREG_BITS +: PREG_BITS];
                ent_mask_q[i][tail_q[i]] <= in_mask[i] & keep_mask;
            end
        end
        if (gnt_any) begin
            out_data_q <= ent_data_q[gnt_idx][gnt_head];
            out_rob_q  <= ent_rob_q[gnt_idx][gnt_head];
            out_rd_q   <= ent_rd_q[gnt_idx][gnt_head];
            out_pd_q   <= ent_pd_q[gnt_idx][gnt_head];
            out_mask_q <= ent_mask_q[gnt_idx][gnt_head] & keep_mask;
        end
    end

    assign cdb_valid = out_valid_q & ~(flush & out_mask_q[br_idx]);
    assign cdb_data  = out_data_q;
    assign cdb_rob   = out_rob_q;
    assign cdb_rd    = out_rd_q;
    assign cdb_pd    = out_pd_q;
endmodule

// File: tb/tb_cdb_arb.sv
// tb_cdb_arb: directed and randomized checks of cdb_arb against a queue-based reference model.
module tb_cdb_arb;
    localparam int NS = 3;
    localparam int FD = 2;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [4:0]  rob;
        logic [4:0]  rd;
        logic [5:0]  pd;
        logic [3:0]  m;
    } ent_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [95:0] src_data;
    logic [14:0] src_rob;
    logic [14:0] src_rd;
    logic [17:0] src_pd;
    logic [11:0] src_mask;
    logic        br_valid;
    logic        br_mispred;
    logic [1:0]  br_idx;
    logic        cdb_valid;
    logic [31:0] cdb_data;
    logic [4:0]  cdb_rob;
    logic [4:0]  cdb_rd;
    logic [5:0]  cdb_pd;

    cdb_arb #(
        .NUM_SRC(3), .FIFO_DEPTH(2), .ROB_BITS(5), .PREG_BITS(6), .BR_BITS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .src_rob(src_rob), .src_rd(src_rd), .src_pd(src_pd), .src_mask(src_mask),
        .br_valid(br_valid), .br_mispred(br_mispred), .br_idx(br_idx),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rob(cdb_rob),
        .cdb_rd(cdb_rd), .cdb_pd(cdb_pd)
    );

    // Reference model: one queue per source holding entries in acceptance order.
    ent_t        mq [NS][$];
    ent_t        mout = '0;
    int          mrr = 0;
    logic        e_valid;
    logic [2:0]  e_ready;
    logic [47:0] e_fields;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic void model_outputs();
        for (int i = 0; i < NS; i++) e_ready[i] = (mq[i].size() < FD);
        e_valid  = mout.v && !(br_valid && br_mispred && mout.m[br_idx]);
        e_fields = {mout.d, mout.rob, mout.rd, mout.pd};
    endfunction

    function automatic void model_step();
        bit         fl;
        bit         acc [NS];
        bit         drp [NS];
        bit         cnd [NS];
        int         g;
        ent_t       e;
        logic [3:0] keep;
        if (rst) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            mrr    = 0;
            mout.v = 1'b0;
            return;
        end
        fl   = br_valid && br_mispred;
        keep = br_valid ? ~(4'b0001 << br_idx) : 4'hF;
        for (int i = 0; i < NS; i++) begin
            acc[i] = src_valid[i] && (mq[i].size() < FD);
            drp[i] = (mq[i].size() > 0) && !mq[i][0].v;
            cnd[i] = (mq[i].size() > 0) && mq[i][0].v && !(fl && mq[i][0].m[br_idx]);
        end
        g = -1;
`ifdef CDB_ARB_MUL_PRIO_EN
        if (cnd[0]) g = 0;
`endif
        if (g < 0) begin
            for (int k = 0; k < NS; k++) if (g < 0 && cnd[(mrr + k) % NS]) g = (mrr + k) % NS;
            if (g >= 0) mrr = (g + 1) % NS;
        end
        if (g >= 0) begin
            e      = mq[g].pop_front();
            e.m    = e.m & keep;
            mout   = e;
        end else begin
            mout.v = 1'b0;
        end
        for (int i = 0; i < NS; i++) if (drp[i]) e = mq[i].pop_front();
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < mq[i].size(); j++) begin
                e = mq[i][j];
                if (fl && e.m[br_idx]) e.v = 1'b0;
                e.m      = e.m & keep;
                mq[i][j] = e;
            end
            if (acc[i]) begin
                e.v   = 1'b1;
                e.d   = src_data[i*32 +: 32];
                e.rob = src_rob[i*5 +: 5];
                e.rd  = src_rd[i*5 +: 5];
                e.pd  = src_pd[i*6 +: 6];
                e.m   = src_mask[i*4 +: 4];
                if (fl && e.m[br_idx]) e.v = 1'b0;
                e.m = e.m & keep;
                mq[i].push_back(e);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        src_valid  = '0;
        src_data   = '0;
        src_rob    = '0;
        src_rd     = '0;
        src_pd     = '0;
        src_mask   = '0;
        br_valid   = 1'b0;
        br_mispred = 1'b0;
        br_idx     = '0;
    endtask

    task automatic drive_src(input int s, input logic [31:0] d, input logic [4:0] rob,
                             input logic [4:0] rd, input logic [5:0] pd, input logic [3:0] m);
        src_valid[s]       = 1'b1;
        src_data[s*32 +: 32] = d;
        src_rob[s*5 +: 5]  = rob;
        src_rd[s*5 +: 5]   = rd;
        src_pd[s*6 +: 6]   = pd;
        src_mask[s*4 +: 4] = m;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        src_valid = 3'b111;
        tick();
        tick();
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        n_tests++;
        if (src_ready !== 3'b111 || cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b cdb_valid=%b, expected ready=111 cdb_valid=0", src_ready, cdb_valid);
        end
        for (int c = 0; c < 3; c++) begin
            if (c > 0) #1;
            model_outputs();
            n_tests++;
            if (cdb_valid !== e_valid || src_ready !== e_ready) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: v=%b rdy=%b, expected v=%b rdy=%b", c, cdb_valid, src_ready, e_valid, e_ready);
            end
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            if (c == 5) drive_src(1, 32'hDEADBEEF, 5'd3, 5'd7, 6'd12, 4'h0);
            #1;
            model_outputs();
            n_tests++;
            if (cdb_valid !== e_valid || src_ready !== e_ready || (e_valid && {cdb_data, cdb_rob, cdb_rd, cdb_pd} !== e_fields)) begin
                n_fail++;
                $display("FAIL single_model c=%0d: v=%b f=%h rdy=%b, expected v=%b f=%h rdy=%b", c, cdb_valid, {cdb_data, cdb_rob, cdb_rd, cdb_pd}, src_ready, e_valid, e_fields, e_ready);
            end
            n_tests++;
            if (cdb_valid !== (c == 7) || (c == 7 && {cdb_data, cdb_rob, cdb_pd} !== {32'hDEADBEEF, 5'd3, 6'd12})) begin
                n_fail++;
                $display("FAIL single_latency c=%0d: v=%b data=%h rob=%0d pd=%0d, expected v=%b data=deadbeef rob=3 pd=12", c, cdb_valid, cdb_data, cdb_rob, cdb_pd, c == 7);
            end
            tick();
        end
    endtask

`ifndef CDB_ARB_MUL_PRIO_EN
    task automatic test_round_robin();
        bit saw_drop = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            clear_inputs();
            if (c >= 2) for (int s = 0; s < NS; s++) drive_src(s, {8'(s), 24'(c)}, 5'(c), 5'(s), 6'(c), 4'h0);
            #1;
            model_outputs();
            if (c <= 6 && src_ready !== 3'b111) saw_drop = 1;
            n_tests++;
            if (cdb_valid !== e_valid || src_ready !== e_ready || (e_valid && {cdb_data, cdb_rob, cdb_rd, cdb_pd} !== e_fields)) begin
                n_fail++;
                $display("FAIL rr_model c=%0d: v=%b f=%h rdy=%b, expected v=%b f=%h rdy=%b", c, cdb_valid, {cdb_data, cdb_rob, cdb_rd, cdb_pd}, src_ready, e_valid, e_fields, e_ready);
            end
            if (c >= 4 && c <= 9) begin
                n_tests++;
                if (cdb_valid !== 1'b1 || cdb_data[31:24] !== 8'((c - 4) % 3)) begin
                    n_fail++;
                    $display("FAIL rr_order c=%0d: v=%b src=%0d, expected v=1 src=%0d", c, cdb_valid, cdb_data[31:24], (c - 4) % 3);
                end
            end
            tick();
        end
        n_tests++;
        if (!saw_drop) begin
            n_fail++;
            $display("FAIL rr_ready_drop: src_ready stayed 111, expected a drop when occupancy hits 2");
        end
    endtask
`endif

    task automatic test_flush();
        bit saw_src1  = 0;
        bit saw_stale = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            if (c == 0) begin
                drive_src(0, 32'hF0000000, 5'd1, 5'd1, 6'd1, 4'b0100);
                drive_src(1, 32'hF1000000, 5'd2, 5'd2, 6'd2, 4'b0000);
            end
            if (c == 1) begin
                br_valid   = 1'b1;
                br_mispred = 1'b1;
                br_idx     = 2'd2;
            end
            if (c == 3) drive_src(0, 32'hF0000003, 5'd4, 5'd4, 6'd4, 4'b0000);
            #1;
            model_outputs();
            if (cdb_valid && cdb_data == 32'hF0000000) saw_stale = 1;
            if (cdb_valid && cdb_data == 32'hF1000000) saw_src1 = 1;
            n_tests++;
            if (cdb_valid !== e_valid || src_ready !== e_ready || (e_valid && {cdb_data, cdb_rob, cdb_rd, cdb_pd} !== e_fields)) begin
                n_fail++;
                $display("FAIL flush_model c=%0d: v=%b f=%h rdy=%b, expected v=%b f=%h rdy=%b", c, cdb_valid, {cdb_data, cdb_rob, cdb_rd, cdb_pd}, src_ready, e_valid, e_fields, e_ready);
            end
            if (c == 5) begin
                n_tests++;
                if (cdb_valid !== 1'b1 || cdb_data !== 32'hF0000003) begin
                    n_fail++;
                    $display("FAIL flush_refill c=%0d: v=%b data=%h, expected v=1 data=f0000003", c, cdb_valid, cdb_data);
                end
            end
            tick();
        end
        n_tests++;
        if (saw_stale || !saw_src1) begin
            n_fail++;
            $display("FAIL flush_result: stale_src0_seen=%b src1_seen=%b, expected 0 and 1", saw_stale, saw_src1);
        end
    endtask

    task automatic test_out_reg();
        for (int mp = 0; mp < 2; mp++) begin
            do_reset();
            for (int c = 0; c < 6; c++) begin
                clear_inputs();
                if (c == 0) drive_src(0, 32'hA5A50000 | 32'(mp), 5'd9, 5'd9, 6'd9, 4'b0010);
                if (c == 2) begin
                    br_valid   = 1'b1;
                    br_mispred = 1'(mp);
                    br_idx     = 2'd1;
                end
                #1;
                model_outputs();
                n_tests++;
                if (cdb_valid !== e_valid || src_ready !== e_ready || (e_valid && {cdb_data, cdb_rob, cdb_rd, cdb_pd} !== e_fields)) begin
                    n_fail++;
                    $display("FAIL outreg_model mp=%0d c=%0d: v=%b f=%h rdy=%b, expected v=%b f=%h rdy=%b", mp, c, cdb_valid, {cdb_data, cdb_rob, cdb_rd, cdb_pd}, src_ready, e_valid, e_fields, e_ready);
                end
                n_tests++;
                if (cdb_valid !== (c == 2 && mp == 0)) begin
                    n_fail++;
                    $display("FAIL outreg_gate mp=%0d c=%0d: cdb_valid=%b, expected %b", mp, c, cdb_valid, c == 2 && mp == 0);
                end
                tick();
            end
        end
    endtask

`ifdef CDB_ARB_MUL_PRIO_EN
    task automatic test_mul_prio();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            clear_inputs();
            if (c < 10) begin
                drive_src(0, {8'd0, 24'(c)}, 5'(c), 5'd0, 6'(c), 4'h0);
                drive_src(2, {8'd2, 24'(c)}, 5'(c), 5'd2, 6'(c), 4'h0);
            end
            #1;
            model_outputs();
            n_tests++;
            if (cdb_valid !== e_valid || src_ready !== e_ready || (e_valid && {cdb_data, cdb_rob, cdb_rd, cdb_pd} !== e_fields)) begin
                n_fail++;
                $display("FAIL prio_model c=%0d: v=%b f=%h rdy=%b, expected v=%b f=%h rdy=%b", c, cdb_valid, {cdb_data, cdb_rob, cdb_rd, cdb_pd}, src_ready, e_valid, e_fields, e_ready);
            end
            if (c >= 2 && c <= 13) begin
                n_tests++;
                if (cdb_valid !== 1'b1 || cdb_data[31:24] !== ((c <= 11) ? 8'd0 : 8'd2)) begin
                    n_fail++;
                    $display("FAIL prio_order c=%0d: v=%b src=%0d, expected v=1 src=%0d", c, cdb_valid, cdb_data[31:24], (c <= 11) ? 0 : 2);
                end
            end
            tick();
        end
    endtask
`endif

    task automatic test_reset_mid();
        bit saw_stale = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            clear_inputs();
            rst = (c == 4 || c == 5);
            if (c < 6) for (int s = 0; s < NS; s++) drive_src(s, {12'hBAD, 20'(c * 4 + s)}, 5'(c), 5'(s), 6'(s), 4'h0);
            if (c == 10) drive_src(2, 32'h600D0002, 5'd2, 5'd2, 6'd2, 4'h0);
            #1;
            model_outputs();
            if (c >= 5 && cdb_valid && cdb_data[31:20] == 12'hBAD) saw_stale = 1;
            n_tests++;
            if (cdb_valid !== e_valid || src_ready !== e_ready || (e_valid && {cdb_data, cdb_rob, cdb_rd, cdb_pd} !== e_fields)) begin
                n_fail++;
                $display("FAIL rstmid_model c=%0d: v=%b f=%h rdy=%b, expected v=%b f=%h rdy=%b", c, cdb_valid, {cdb_data, cdb_rob, cdb_rd, cdb_pd}, src_ready, e_valid, e_fields, e_ready);
            end
            if (c >= 5 && c <= 11) begin
                n_tests++;
                if (cdb_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_quiet c=%0d: cdb_valid=%b data=%h, expected cdb_valid=0", c, cdb_valid, cdb_data);
                end
            end
            tick();
        end
        rst = 1'b0;
        n_tests++;
        if (saw_stale) begin
            n_fail++;
            $display("FAIL rstmid_stale: stale pre-reset entry broadcast=%b, expected 0", saw_stale);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            clear_inputs();
            rst = ($urandom_range(0, 299) == 0);
            for (int s = 0; s < NS; s++) begin
                if ($urandom_range(0, 9) < 6)
                    drive_src(s, $urandom(), 5'($urandom()), 5'($urandom()), 6'($urandom()), 4'($urandom() & $urandom()));
            end
            br_valid   = ($urandom_range(0, 3) == 0);
            br_mispred = 1'($urandom_range(0, 1));
            br_idx     = 2'($urandom_range(0, 3));
            #1;
            model_outputs();
            n_tests++;
            if (cdb_valid !== e_valid || src_ready !== e_ready || (e_valid && {cdb_data, cdb_rob, cdb_rd, cdb_pd} !== e_fields)) begin
                n_fail++;
                $display("FAIL random c=%0d: v=%b f=%h rdy=%b, expected v=%b f=%h rdy=%b", c, cdb_valid, {cdb_data, cdb_rob, cdb_rd, cdb_pd}, src_ready, e_valid, e_fields, e_ready);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
`ifndef CDB_ARB_MUL_PRIO_EN
        test_round_robin();
`else
        test_mul_prio();
`endif
        test_flush();
        test_out_reg();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
